// File: rtl/bcd_serial_adder_pkg.sv
// Shared constants for the digit-serial BCD adder: FSM encodings and BCD digit limits.
package bcd_serial_adder_pkg;

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_RUN  = 2'd1;
  localparam logic [1:0] ST_DONE = 2'd2;

  localparam logic [3:0] BCD_MAX  = 4'd9;
  localparam logic [3:0] BCD_CORR = 4'd6;

  function automatic logic nibble_bad(input logic [3:0] n);
    return n > BCD_MAX;
  endfunction

endpackage

// File: rtl/bcd_digit_add.sv
// One-digit BCD adder with decimal correction; flags any non-BCD input nibble.
module bcd_digit_add
  import bcd_serial_adder_pkg::*;
(
  input  logic [3:0] a_d,
  input  logic [3:0] b_d,
  input  logic       c_in,
  output logic [3:0] s_d,
  output logic       c_out,
  output logic       bad
);

  logic [4:0] z;
  logic [3:0] z_corr;

  // Only the low nibble of z + 6 matters, so the correction is done mod 16.
  always_comb begin
    z      = 5'(a_d) + 5'(b_d) + 5'(c_in);
    z_corr = z[3:0] + BCD_CORR;
    s_d    = z[3:0];
    c_out  = 1'b0;
    if (z > 5'(BCD_MAX)) begin
      s_d   = z_corr;
      c_out = 1'b1;
    end
    bad = nibble_bad(a_d) | nibble_bad(b_d);
  end

endmodule

// File: rtl/bcd_serial_adder.sv
// Digit-serial multi-digit BCD adder: one digit per clock, least significant digit first.
module bcd_serial_adder
  import bcd_serial_adder_pkg::*;
#(
  parameter int unsigned DIGITS = 4
) (
  input  logic                clk,
  input  logic                resetn,
  input  logic                start,
  input  logic [4*DIGITS-1:0] a,
  input  logic [4*DIGITS-1:0] b,
  input  logic                cin,
  output logic                busy,
  output logic                done,
  output logic [4*DIGITS-1:0] sum,
  output logic                cout,
  output logic                invalid
);

  localparam int unsigned W  = 4 * DIGITS;
  localparam int unsigned CW = $clog2(DIGITS + 1);

  logic [1:0]    state_q,   state_d;
  logic [CW-1:0] cnt_q,     cnt_d;
  logic [W-1:0]  a_sh_q,    a_sh_d;
  logic [W-1:0]  b_sh_q,    b_sh_d;
  logic [W-1:0]  res_sh_q,  res_sh_d;
  logic          carry_q,   carry_d;
  logic          inv_acc_q, inv_acc_d;
  logic          busy_q,    busy_d;
  logic          done_q,    done_d;
  logic [W-1:0]  sum_q,     sum_d;
  logic          cout_q,    cout_d;
  logic          invalid_q, invalid_d;

  logic [3:0]    dig_s;
  logic          dig_c;
  logic          dig_bad;
  logic [W-1:0]  res_next;
  logic          last_digit;

  bcd_digit_add u_digit (
    .a_d   (a_sh_q[3:0]),
    .b_d   (b_sh_q[3:0]),
    .c_in  (carry_q),
    .s_d   (dig_s),
    .c_out (dig_c),
    .bad   (dig_bad)
  );

  // New digit enters at the top; after DIGITS shifts digit 0 sits in the low nibble.
  assign res_next   = W'({dig_s, res_sh_q} >> 4);
  assign last_digit = (cnt_q == CW'(DIGITS - 1));

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    a_sh_d    = a_sh_q;
    b_sh_d    = b_sh_q;
    res_sh_d  = res_sh_q;
    carry_d   = carry_q;
    inv_acc_d = inv_acc_q;
    busy_d    = busy_q;
    done_d    = 1'b0;
    sum_d     = sum_q;
    cout_d    = cout_q;
    invalid_d = invalid_q;

    case (state_q)
      ST_IDLE: begin
        if (start) begin
          a_sh_d    = a;
          b_sh_d    = b;
          carry_d   = cin;
          cnt_d     = '0;
          res_sh_d  = '0;
          inv_acc_d = 1'b0;
          busy_d    = 1'b1;
          state_d   = ST_RUN;
        end
      end
      ST_RUN: begin
        res_sh_d  = res_next;
        a_sh_d    = a_sh_q >> 4;
        b_sh_d    = b_sh_q >> 4;
        carry_d   = dig_c;
        inv_acc_d = inv_acc_q | dig_bad;
        cnt_d     = cnt_q + CW'(1);
        if (last_digit) begin
          sum_d     = res_next;
          cout_d    = dig_c;
          invalid_d = inv_acc_q | dig_bad;
          done_d    = 1'b1;
          state_d   = ST_DONE;
        end
      end
      ST_DONE: begin
        busy_d  = 1'b0;
        state_d = ST_IDLE;
      end
      default: begin
        busy_d  = 1'b0;
        state_d = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (!resetn) begin
      state_q   <= ST_IDLE;
      cnt_q     <= '0;
      a_sh_q    <= '0;
      b_sh_q    <= '0;
      res_sh_q  <= '0;
      carry_q   <= 1'b0;
      inv_acc_q <= 1'b0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
      sum_q     <= '0;
      cout_q    <= 1'b0;
      invalid_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      a_sh_q    <= a_sh_d;
      b_sh_q    <= b_sh_d;
      res_sh_q  <= res_sh_d;
      carry_q   <= carry_d;
      inv_acc_q <= inv_acc_d;
      busy_q    <= busy_d;
      done_q    <= done_d;
      sum_q     <= sum_d;
      cout_q    <= cout_d;
      invalid_q <= invalid_d;
    end
  end

  assign busy    = busy_q;
  assign done    = done_q;
  assign sum     = sum_q;
  assign cout    = cout_q;
  assign invalid = invalid_q;

endmodule

// File: tb/tb_bcd_serial_adder.sv
// Self-checking bench: decimal-arithmetic reference model plus directed operand vectors.
module tb_bcd_serial_adder;

  localparam int unsigned DIGITS = 4;
  localparam int unsigned W      = 4 * DIGITS;

  logic         clk = 1'b0;
  logic         resetn;
  logic         start;
  logic [W-1:0] a;
  logic [W-1:0] b;
  logic         cin;
  logic         busy;
  logic         done;
  logic [W-1:0] sum;
  logic         cout;
  logic         invalid;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  bcd_serial_adder #(.DIGITS(DIGITS)) dut (
    .clk     (clk),
    .resetn  (resetn),
    .start   (start),
    .a       (a),
    .b       (b),
    .cin     (cin),
    .busy    (busy),
    .done    (done),
    .sum     (sum),
    .cout    (cout),
    .invalid (invalid)
  );

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Reference model: decimal value of the operands, added as integers.
  function automatic longint bcd_val(input logic [W-1:0] x);
    longint v = 0;
    for (int i = DIGITS - 1; i >= 0; i--) v = v * 10 + longint'(x[4*i +: 4]);
    return v;
  endfunction

  function automatic logic [W-1:0] to_bcd(input longint v);
    logic [W-1:0] r = '0;
    for (int i = 0; i < DIGITS; i++) begin
      r[4*i +: 4] = 4'(v % 10);
      v = v / 10;
    end
    return r;
  endfunction

  function automatic logic all_bcd(input logic [W-1:0] x);
    for (int i = 0; i < DIGITS; i++) if (x[4*i +: 4] > 4'd9) return 1'b0;
    return 1'b1;
  endfunction

  function automatic logic [W:0] model_add(input logic [W-1:0] x, input logic [W-1:0] y,
                                           input logic c);
    longint lim = 1;
    longint t;
    for (int i = 0; i < DIGITS; i++) lim = lim * 10;
    t = bcd_val(x) + bcd_val(y) + longint'(c);
    return {t >= lim, to_bcd(t % lim)};
  endfunction

  // Model timeline: remaining busy cycles after an accepted start.
  int           rem = 0;
  logic         m_live = 1'b0;
  logic [W-1:0] p_sum, m_sum;
  logic         p_cout, m_cout, p_inv, m_inv, p_known, m_known;

  always @(posedge clk) begin
    m_live <= 1'b1;
    if (!resetn) begin
      rem     <= 0;
      m_sum   <= '0;
      m_cout  <= 1'b0;
      m_inv   <= 1'b0;
      m_known <= 1'b1;
    end else if (rem == 0) begin
      if (start) begin
        rem     <= DIGITS + 1;
        {p_cout, p_sum} <= model_add(a, b, cin);
        p_inv   <= !(all_bcd(a) && all_bcd(b));
        p_known <= all_bcd(a) && all_bcd(b);
      end
    end else begin
      rem <= rem - 1;
      if (rem == 2) begin
        m_sum   <= p_sum;
        m_cout  <= p_cout;
        m_inv   <= p_inv;
        m_known <= p_known;
      end
    end
  end

  always @(negedge clk) begin
    if (m_live) begin
      check("busy", 64'(busy), 64'(rem != 0));
      check("done", 64'(done), 64'(rem == 1));
      check("invalid", 64'(invalid), 64'(m_inv));
      if (m_known) begin
        check("sum", 64'(sum), 64'(m_sum));
        check("cout", 64'(cout), 64'(m_cout));
      end
    end
  end

  task automatic run_op(input logic [W-1:0] ai, input logic [W-1:0] bi, input logic ci,
                        input logic [W-1:0] es, input logic ec, input logic ei,
                        input logic chk_sum);
    int k;
    @(negedge clk);
    a = ai; b = bi; cin = ci; start = 1'b1;
    @(posedge clk);
    @(negedge clk);
    start = 1'b0;
    a = ~ai; b = ~bi; cin = ~ci;
    k = 0;
    while (!done && k < 20) begin
      k++;
      @(negedge clk);
    end
    check("latency", 64'(k), 64'(DIGITS));
    check("lit_invalid", 64'(invalid), 64'(ei));
    if (chk_sum) begin
      check("lit_sum", 64'(sum), 64'(es));
      check("lit_cout", 64'(cout), 64'(ec));
    end
    @(negedge clk);
  endtask

  logic [W-1:0] tab_a [4] = '{16'h0123, 16'h9999, 16'h5000, 16'h0808};
  logic [W-1:0] tab_b [4] = '{16'h0456, 16'h0001, 16'h4999, 16'h0192};

  initial begin
    int n_done;
    int pos [8];
    resetn = 1'b0; start = 1'b0; a = '0; b = '0; cin = 1'b0;
    repeat (2) @(negedge clk);
    check("rst_busy", 64'(busy), 64'(0));
    check("rst_done", 64'(done), 64'(0));
    check("rst_sum", 64'(sum), 64'(0));
    check("rst_cout", 64'(cout), 64'(0));
    check("rst_invalid", 64'(invalid), 64'(0));
    resetn = 1'b1;

    run_op(16'h1234, 16'h5678, 1'b0, 16'h6912, 1'b0, 1'b0, 1'b1);
    run_op(16'h9999, 16'h0001, 1'b0, 16'h0000, 1'b1, 1'b0, 1'b1);
    run_op(16'h4321, 16'h5678, 1'b1, 16'h0000, 1'b1, 1'b0, 1'b1);
    run_op(16'h00A0, 16'h0000, 1'b0, 16'h0000, 1'b0, 1'b1, 1'b0);
    run_op(16'h0005, 16'h0004, 1'b0, 16'h0009, 1'b0, 1'b0, 1'b1);
    run_op(16'h9999, 16'h9999, 1'b1, 16'h9999, 1'b1, 1'b0, 1'b1);

    // Abort by reset after two digits.
    @(negedge clk);
    a = 16'h1111; b = 16'h2222; cin = 1'b0; start = 1'b1;
    @(posedge clk);
    @(negedge clk);
    start = 1'b0;
    @(posedge clk);
    @(negedge clk);
    resetn = 1'b0;
    @(posedge clk);
    @(negedge clk);
    resetn = 1'b1;
    check("abort_busy", 64'(busy), 64'(0));
    check("abort_sum", 64'(sum), 64'(0));
    check("abort_cout", 64'(cout), 64'(0));
    n_done = 0;
    repeat (10) begin
      @(negedge clk);
      if (done) n_done++;
    end
    check("abort_no_done", 64'(n_done), 64'(0));

    // Start pulsed again during RUN is ignored.
    a = 16'h0321; b = 16'h0123; start = 1'b1;
    @(posedge clk);
    @(negedge clk);
    start = 1'b0;
    @(negedge clk);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    n_done = 0;
    repeat (20) begin
      @(negedge clk);
      if (done) n_done++;
    end
    check("run_start_ignored", 64'(n_done), 64'(1));
    check("run_start_sum", 64'(sum), 64'(16'h0444));

    // Start held high with operands changing every cycle.
    n_done = 0;
    for (int n = 0; n < 24; n++) begin
      if (n > 0) @(negedge clk);
      if (done && n_done < 8) begin
        pos[n_done] = n;
        if (n_done == 0) check("held_first_sum", 64'(sum), 64'(16'h0579));
        n_done++;
      end
      a = tab_a[n % 4]; b = tab_b[n % 4]; cin = 1'b0; start = 1'b1;
    end
    start = 1'b0;
    check("held_done_count", 64'(n_done >= 3), 64'(1));
    for (int i = 1; i < n_done && i < 8; i++)
      check("held_spacing", 64'(pos[i] - pos[i-1]), 64'(DIGITS + 2));
    repeat (8) @(negedge clk);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not complete, got no finish, expected finish");
    $fatal(1);
  end

endmodule
